logic_writeback: RTL and testbench
==================================

Name: logic_writeback

Overview:
- Final stage of the game-of-life update pipeline.
- Collects the NUM_PE next-state bits the processing elements produce each cycle and packs them into WORD_SIZE-bit words.
- Writes each completed word to the next-generation board memory at sequential word addresses.
- A generation starts on start_in and ends after the last word of the board is written.

Parameters:
- NUM_PE, 1: cells produced per cycle. WORD_SIZE must be a multiple of NUM_PE.
- WORD_SIZE, 32: bits per memory word (data_t width).
- BOARD_WIDTH, 512: board width in cells.
- BOARD_HEIGHT, 512: board height in cells.
- ADDR_WIDTH, $clog2(BOARD_WIDTH*BOARD_HEIGHT/WORD_SIZE): word address width (addr_t).

Ports:
- clk_in  input  1  system clock; the only clock.
- rst_in  input  1  synchronous, active-high reset.
- stall_in  input  1  pipeline stall; next_state_in is invalid this cycle.
- start_in  input  1  first cycle of a new generation.
- next_state_in  input  NUM_PE  next states of NUM_PE consecutive cells, lowest index = earliest cell.
- wr_en_out  output  1  memory write strobe, one cycle per word.
- addr_w_out  output  ADDR_WIDTH  word address of the write.
- data_w_out  output  WORD_SIZE  packed word.

Behaviour:
- All state updates on the rising edge of clk_in. All outputs are registered.
- Reset (rst_in=1, sampled on the clock edge):
  - wr_en_out=0, addr_w_out=0, data_w_out=0.
  - Internal word buffer cleared, bit counter=0, word pointer=0, FSM=IDLE.
  - Reset has priority over every other input, including mid-word and mid-generation.
- FSM states:
  - IDLE: ignores next_state_in and stall_in. On start_in go to RUN.
  - RUN: packs bits and writes words.
- Start handling:
  - start_in (in any state) clears the bit counter and word pointer and discards any partial word.
  - If stall_in=0 on the start cycle, next_state_in on that cycle is captured as bits [NUM_PE-1:0] of word 0.
  - If stall_in=1 on the start cycle, only the restart happens; the first capture occurs on the next unstalled cycle.
- Capture in RUN with stall_in=0:
  - next_state_in is placed at bits [k*NUM_PE +: NUM_PE] of the buffer, where k is the bit counter (count of captures so far in this word).
  - The counter then increments.
  - Cell order within a word: the earliest cell is at bit 0.
- Capture in RUN with stall_in=1: no capture and no counter change; next_state_in is ignored.
- Word completion:
  - On the cycle that makes the WORD_SIZE/NUM_PE-th capture, the completed word (including that cycle's bits) is registered to data_w_out. The word pointer goes to addr_w_out and wr_en_out=1 on the following cycle. Latency is one cycle from the final capture to the strobe.
  - The counter returns to 0 and the word pointer increments.
  - wr_en_out is high for exactly one cycle per word and is independent of stall_in in that cycle.
  - Capture of the next word proceeds in the same cycle as the strobe, so back-to-back words need no gap.
- End of generation:
  - After the write of word BOARD_WIDTH*BOARD_HEIGHT/WORD_SIZE-1, the word pointer wraps to 0 and the FSM returns to IDLE.
  - Further next_state_in is ignored until the next start_in.
- Held outputs: when wr_en_out=0, addr_w_out and data_w_out hold their last values.
- No write is issued for a partial word.

Test Plan:
- Reset behaviour: assert rst_in 2 cycles, then idle with next_state_in=1 and no start. Required: wr_en_out stays 0, addr_w_out=0, data_w_out=0.
- Full word, NUM_PE=1, WORD_SIZE=32:
  - Stimulus: start_in=1 with bit 1 on the start cycle, then 31 unstalled cycles of bits 0,1,0,1,...
  - Required: one-cycle wr_en_out, one cycle after the 32nd bit, with addr_w_out=0 and data_w_out=0x5555_5555.
- Consecutive words: continue with 32 cycles of bit 1. Required: second strobe with addr_w_out=1 and data_w_out=0xFFFF_FFFF; no extra strobes.
- Stall mid-word:
  - Stimulus: after 4 captured 1s, hold stall_in=1 for 2 cycles with next_state_in=0, then supply 28 more 1s.
  - Required: data_w_out=0xFFFF_FFFF. The strobe is delayed by exactly 2 cycles relative to the unstalled case.
- Restart mid-word: after 10 captures, pulse start_in with bit 0, then 31 cycles of bit 1. Required: the partial word is discarded; the write has addr_w_out=0 and data_w_out=0xFFFF_FFFE.
- Generation end (small board, 64 cells):
  - Stimulus: feed 64 unstalled bits, then more bits without start_in.
  - Required: strobes at addresses 0 and 1 only; the extra bits are ignored, and the next start_in writes address 0 again.

Source files
------------

// File: rtl/logic_writeback.sv
// Final stage of the game-of-life update pipeline: packs next-state bits into
// words and writes them to the next-generation board memory at sequential addresses.
module logic_writeback #(
    parameter int NUM_PE       = 1,
    parameter int WORD_SIZE    = 32,
    parameter int BOARD_WIDTH  = 512,
    parameter int BOARD_HEIGHT = 512,
    parameter int ADDR_WIDTH   = $clog2(BOARD_WIDTH*BOARD_HEIGHT/WORD_SIZE)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  stall_in,
    input  logic                  start_in,
    input  logic [NUM_PE-1:0]     next_state_in,
    output logic                  wr_en_out,
    output logic [ADDR_WIDTH-1:0] addr_w_out,
    output logic [WORD_SIZE-1:0]  data_w_out
);

    localparam int CAPS      = WORD_SIZE / NUM_PE;
    localparam int CNT_W     = (CAPS > 1) ? $clog2(CAPS) : 1;
    localparam int NUM_WORDS = BOARD_WIDTH * BOARD_HEIGHT / WORD_SIZE;
    localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(CAPS - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state;
    logic [WORD_SIZE-1:0]  word_buf_p0;
    logic [CNT_W-1:0]      bit_cnt_p0;
    logic [ADDR_WIDTH-1:0] word_ptr_p0;

    logic                  capture;
    logic                  word_done;
    logic [CNT_W-1:0]      slot;
    logic [WORD_SIZE-1:0]  base_buf;
    logic [WORD_SIZE-1:0]  next_buf;
    logic [ADDR_WIDTH-1:0] base_ptr;

    function automatic logic [WORD_SIZE-1:0] insert_bits(
        input logic [WORD_SIZE-1:0] base,
        input logic [CNT_W-1:0]     pos,
        input logic [NUM_PE-1:0]    bits
    );
        logic [WORD_SIZE-1:0] r;
        r = base;
        for (int i = 0; i < CAPS; i++) begin
            if (pos == CNT_W'(i)) r[i*NUM_PE +: NUM_PE] = bits;
        end
        return r;
    endfunction

    // A start cycle behaves as a capture into an empty word 0, so a restart and
    // its first capture (when unstalled) resolve in the same cycle.
    always_comb begin
        capture   = !stall_in && (start_in || state == RUN);
        slot      = start_in ? '0 : bit_cnt_p0;
        base_buf  = start_in ? '0 : word_buf_p0;
        base_ptr  = start_in ? '0 : word_ptr_p0;
        next_buf  = insert_bits(base_buf, slot, next_state_in);
        word_done = capture && (slot == LAST_CNT);
    end

    // p0 -> output register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= IDLE;
            word_buf_p0 <= '0;
            bit_cnt_p0  <= '0;
            word_ptr_p0 <= '0;
            wr_en_out   <= 1'b0;
            addr_w_out  <= '0;
            data_w_out  <= '0;
        end else begin
            wr_en_out <= 1'b0;
            if (start_in) state <= RUN;

            if (word_done) begin
                data_w_out  <= next_buf;
                addr_w_out  <= base_ptr;
                wr_en_out   <= 1'b1;
                word_buf_p0 <= '0;
                bit_cnt_p0  <= '0;
                if (base_ptr == LAST_ADDR) begin
                    word_ptr_p0 <= '0;
                    state       <= IDLE;
                end else begin
                    word_ptr_p0 <= base_ptr + ADDR_WIDTH'(1);
                end
            end else if (capture) begin
                word_buf_p0 <= next_buf;
                bit_cnt_p0  <= slot + CNT_W'(1);
                word_ptr_p0 <= base_ptr;
            end else if (start_in) begin
                word_buf_p0 <= '0;
                bit_cnt_p0  <= '0;
                word_ptr_p0 <= '0;
            end
        end
    end

endmodule

// File: tb/tb_logic_writeback.sv
// Directed bench for logic_writeback: a full-size board instance and a
// 64-cell board instance for the end-of-generation behaviour.
module tb_logic_writeback;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc_n = 0;
    int          total = 0;
    int          bad = 0;

    logic        stall_m, start_m;
    logic [0:0]  ns_m;
    logic        wr_m;
    logic [12:0] addr_m;
    logic [31:0] data_m;

    logic        stall_s, start_s;
    logic [0:0]  ns_s;
    logic        wr_s;
    logic [0:0]  addr_s;
    logic [31:0] data_s;

    typedef struct {
        int          cyc;
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t qm[$];
    wr_t qs[$];

    logic_writeback u_main (
        .clk_in(clk), .rst_in(rst), .stall_in(stall_m), .start_in(start_m),
        .next_state_in(ns_m), .wr_en_out(wr_m), .addr_w_out(addr_m), .data_w_out(data_m)
    );

    logic_writeback #(.BOARD_WIDTH(8), .BOARD_HEIGHT(8)) u_small (
        .clk_in(clk), .rst_in(rst), .stall_in(stall_s), .start_in(start_s),
        .next_state_in(ns_s), .wr_en_out(wr_s), .addr_w_out(addr_s), .data_w_out(data_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        if (wr_m === 1'b1) qm.push_back('{cyc_n, int'(addr_m), data_m});
        if (wr_s === 1'b1) qs.push_back('{cyc_n, int'(addr_s), data_s});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drv_m(input logic s, input logic st, input logic b);
        start_m = s; stall_m = st; ns_m = b;
        @(posedge clk); #1;
    endtask

    task automatic drv_s(input logic s, input logic st, input logic b);
        start_s = s; stall_s = st; ns_s = b;
        @(posedge clk); #1;
    endtask

    int s0;

    initial begin
        rst = 1'b1;
        start_m = 0; stall_m = 0; ns_m = 0;
        start_s = 0; stall_s = 0; ns_s = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state, then idle with next_state=1 and no start
        ns_m = 1; ns_s = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_wr", wr_m, 0);
            check("rst_addr", addr_m, 0);
            check("rst_data", data_m, 0);
        end
        check("rst_small_wr", wr_s, 0);
        check("idle_no_strobe", qm.size() + qs.size(), 0);
        ns_s = 0; stall_s = 1;

        // Full word 0x55555555, one cycle after the 32nd bit
        qm.delete();
        drv_m(1, 0, 1);
        s0 = cyc_n;
        for (int i = 1; i < 32; i++) drv_m(0, 0, (i % 2) == 0);
        // Consecutive word of all ones
        for (int i = 0; i < 32; i++) drv_m(0, 0, 1);
        for (int i = 0; i < 4; i++) drv_m(0, 1, 0);
        check("w01_count", qm.size(), 2);
        if (qm.size() >= 2) begin
            check("w0_cyc", qm[0].cyc - s0, 31);
            check("w0_addr", qm[0].addr, 0);
            check("w0_data", qm[0].data, 32'h5555_5555);
            check("w1_cyc", qm[1].cyc - s0, 63);
            check("w1_addr", qm[1].addr, 1);
            check("w1_data", qm[1].data, 32'hFFFF_FFFF);
        end

        // Stall mid-word: strobe moves out by exactly 2 cycles
        qm.delete();
        drv_m(1, 0, 1);
        s0 = cyc_n;
        for (int i = 0; i < 3; i++) drv_m(0, 0, 1);
        drv_m(0, 1, 0);
        drv_m(0, 1, 0);
        for (int i = 0; i < 28; i++) drv_m(0, 0, 1);
        for (int i = 0; i < 3; i++) drv_m(0, 1, 0);
        check("stall_count", qm.size(), 1);
        if (qm.size() >= 1) begin
            check("stall_cyc", qm[0].cyc - s0, 33);
            check("stall_addr", qm[0].addr, 0);
            check("stall_data", qm[0].data, 32'hFFFF_FFFF);
        end

        // Restart mid-word: partial word discarded
        qm.delete();
        drv_m(1, 0, 1);
        for (int i = 0; i < 9; i++) drv_m(0, 0, 1);
        drv_m(1, 0, 0);
        for (int i = 0; i < 31; i++) drv_m(0, 0, 1);
        for (int i = 0; i < 3; i++) drv_m(0, 1, 0);
        check("restart_count", qm.size(), 1);
        if (qm.size() >= 1) begin
            check("restart_addr", qm[0].addr, 0);
            check("restart_data", qm[0].data, 32'hFFFF_FFFE);
        end

        // Stalled start cycle: its bit is not captured
        qm.delete();
        drv_m(1, 1, 1);
        for (int i = 0; i < 32; i++) drv_m(0, 0, (i % 2) == 1);
        for (int i = 0; i < 3; i++) drv_m(0, 1, 0);
        check("stallstart_count", qm.size(), 1);
        if (qm.size() >= 1) begin
            check("stallstart_addr", qm[0].addr, 0);
            check("stallstart_data", qm[0].data, 32'hAAAA_AAAA);
        end
        stall_m = 1;

        // Generation end on the 64-cell board
        qs.delete();
        drv_s(1, 0, 1);
        for (int i = 1; i < 64; i++) drv_s(0, 0, (i < 16) || (i >= 32));
        for (int i = 0; i < 40; i++) drv_s(0, 0, 1);
        check("gen_count", qs.size(), 2);
        if (qs.size() >= 2) begin
            check("gen_w0_addr", qs[0].addr, 0);
            check("gen_w0_data", qs[0].data, 32'h0000_FFFF);
            check("gen_w1_addr", qs[1].addr, 1);
            check("gen_w1_data", qs[1].data, 32'hFFFF_FFFF);
        end
        check("gen_hold_addr", addr_s, 1);
        check("gen_hold_data", data_s, 32'hFFFF_FFFF);
        qs.delete();
        drv_s(1, 0, 1);
        for (int i = 1; i < 32; i++) drv_s(0, 0, 1);
        for (int i = 0; i < 3; i++) drv_s(0, 1, 0);
        check("gen2_count", qs.size(), 1);
        if (qs.size() >= 1) begin
            check("gen2_addr", qs[0].addr, 0);
            check("gen2_data", qs[0].data, 32'hFFFF_FFFF);
        end

        // Reset mid-word clears outputs
        drv_s(1, 0, 1);
        for (int i = 0; i < 5; i++) drv_s(0, 0, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_addr", addr_s, 0);
        check("midrst_data", data_s, 0);
        check("midrst_wr", wr_s, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
